// File: rtl/instr_mem_loader_pkg.sv
// Shared widths, window geometry and FSM encoding for the instruction-memory loader.
package instr_mem_loader_pkg;

  // Defaults mirroring the wasm instruction-BRAM geometry.
  localparam int INSTR_LOG2_BRAM_DEPTH = 8;
  localparam int INSTR_BRAM_WIDTH      = 8;
  localparam int INSTR_BRAM_DEPTH      = 256;
  localparam int WRITE_WINDOW_SIZE     = 4;
  localparam int LOG_WRITE_WINDOW_SIZE = 2;
  localparam int BYTE_COUNT_WIDTH      = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2
  } state_e;

endpackage

// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: packs a byte stream into write windows and
// issues one window write per window into the instruction BRAM, starting at
// a programmable base address. Loads that would run past the end of the
// BRAM are rejected up front and flagged.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = INSTR_LOG2_BRAM_DEPTH,
  parameter int DATA_WIDTH = INSTR_BRAM_WIDTH,
  parameter int DEPTH      = INSTR_BRAM_DEPTH,
  parameter int WINDOW     = WRITE_WINDOW_SIZE,
  parameter int LOG_WINDOW = LOG_WRITE_WINDOW_SIZE
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic [BYTE_COUNT_WIDTH-1:0]  byte_count,
  input  logic                         s_valid,
  input  logic [DATA_WIDTH-1:0]        s_data,
  output logic                         s_ready,
  output logic                         we,
  output logic [ADDR_WIDTH-1:0]        wr_addr,
  output logic [WINDOW*DATA_WIDTH-1:0] wr_data,
  output logic [LOG_WINDOW-1:0]        wr_shift_minusone,
  output logic [ADDR_WIDTH-1:0]        write_pointer_out,
  output logic                         busy,
  output logic                         done,
  output logic                         err_overflow
);

  // fill_cnt must be able to hold WINDOW itself, hence one extra bit.
  localparam int                CNT_W       = LOG_WINDOW + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT    = CNT_W'(WINDOW);
  localparam int                END_W       = BYTE_COUNT_WIDTH + 1;
  localparam logic [END_W-1:0]  DEPTH_LIMIT = END_W'(DEPTH);

  state_e                              state;
  logic [ADDR_WIDTH-1:0]               write_pointer;
  logic [BYTE_COUNT_WIDTH-1:0]         remaining;
  logic [CNT_W-1:0]                    fill_cnt;
  logic [WINDOW-1:0][DATA_WIDTH-1:0]   lanes;
  logic [WINDOW-1:0][DATA_WIDTH-1:0]   next_lanes;
  logic [END_W-1:0]                    session_end;
  logic                                accept;
  logic                                last_byte;

  // Session end computed one bit wider than byte_count so the range check cannot wrap.
  assign session_end = END_W'(base_addr) + END_W'(byte_count);

  // s_ready is only ever high in FILL, so this is the FILL-state accept.
  assign accept    = s_valid & s_ready;
  assign last_byte = (CNT_W'(fill_cnt + CNT_W'(1)) == FULL_CNT) ||
                     (remaining == BYTE_COUNT_WIDTH'(1));

  assign write_pointer_out = write_pointer;

  // Lane packer: current lanes with the incoming byte dropped into slot fill_cnt.
  always_comb begin
    // NOTE: default-assign every always_comb output first so no path leaves it unassigned (no latch).
    next_lanes = lanes;
    next_lanes[fill_cnt[LOG_WINDOW-1:0]] = s_data;
  end

  // Loader FSM: session setup, byte packing, window write and pointer advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      write_pointer     <= '0;
      remaining         <= '0;
      fill_cnt          <= '0;
      // NOTE: the lane bank is a handful of flops, not a RAM, so it is reset with everything else.
      lanes             <= '0;
      s_ready           <= 1'b0;
      we                <= 1'b0;
      wr_addr           <= '0;
      wr_data           <= '0;
      wr_shift_minusone <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err_overflow      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      done              <= 1'b0;
      we                <= 1'b0;
      wr_addr           <= '0;
      wr_data           <= '0;
      wr_shift_minusone <= '0;

      unique case (state)
        S_IDLE: begin
          if (start) begin
            err_overflow  <= 1'b0;
            write_pointer <= base_addr;
            remaining     <= byte_count;
            fill_cnt      <= '0;
            if (byte_count == '0) begin
              done <= 1'b1;
            end else if (session_end > DEPTH_LIMIT) begin
              err_overflow <= 1'b1;
              done         <= 1'b1;
            end else begin
              state   <= S_FILL;
              s_ready <= 1'b1;
              busy    <= 1'b1;
            end
          end
        end

        S_FILL: begin
          if (accept) begin
            lanes     <= next_lanes;
            fill_cnt  <= CNT_W'(fill_cnt + CNT_W'(1));
            remaining <= remaining - BYTE_COUNT_WIDTH'(1);
            if (last_byte) begin
              // Present the completed window directly from the packer so we
              // rises exactly one cycle after the final byte is accepted.
              state             <= S_WRITE;
              s_ready           <= 1'b0;
              we                <= 1'b1;
              wr_addr           <= write_pointer;
              wr_data           <= next_lanes;
              wr_shift_minusone <= fill_cnt[LOG_WINDOW-1:0];
            end
          end
        end

        S_WRITE: begin
          write_pointer <= write_pointer + ADDR_WIDTH'(fill_cnt);
          lanes         <= '0;
          fill_cnt      <= '0;
          if (remaining == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state   <= S_FILL;
            s_ready <= 1'b1;
          end
        end

        default: begin
          state   <= S_IDLE;
          s_ready <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed sessions from the test
// plan plus randomized sessions, each compared against a window-level model.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [15:0] byte_count = '0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready;
  logic        we;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  wr_shift_minusone;
  logic [7:0]  write_pointer_out;
  logic        busy;
  logic        done;
  logic        err_overflow;

  instr_mem_loader dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .base_addr         (base_addr),
    .byte_count        (byte_count),
    .s_valid           (s_valid),
    .s_data            (s_data),
    .s_ready           (s_ready),
    .we                (we),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .wr_shift_minusone (wr_shift_minusone),
    .write_pointer_out (write_pointer_out),
    .busy              (busy),
    .done              (done),
    .err_overflow      (err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [1:0]  shift;
  } wr_t;

  int  cyc = 0;
  int  n_assert = 0;
  int  n_fail = 0;
  int  proto_errs = 0;
  wr_t we_q[$];
  int  done_q[$];
  int  acc_q[$];

  always @(posedge clk) cyc++;

  // Observe the write port and done pulse away from the active edge.
  always @(negedge clk) begin
    if (we) we_q.push_back('{cyc, wr_addr, wr_data, wr_shift_minusone});
    else if (wr_addr != 0 || wr_data != 0 || wr_shift_minusone != 0) proto_errs++;
    if (we && s_ready) proto_errs++;
    if (!busy && (s_ready || we)) proto_errs++;
    if (done) done_q.push_back(cyc);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " flags"}, 64'({s_ready, we, busy, done, err_overflow}), 64'd0);
    check({tag, " wr bus"}, 64'({wr_addr, wr_data, wr_shift_minusone}), 64'd0);
    check({tag, " pointer"}, 64'(write_pointer_out), 64'd0);
  endtask

  // One complete load session: drive, then compare against the model.
  task automatic run_session(input logic [7:0] base, input int cnt, input int pct,
                             input bit seq, input bit poke);
    logic [7:0] bytes[$];
    bit         reject;
    bit         poked;
    int         i, budget, nwin, lanes_n, idx, w;
    logic [31:0] exp_data;

    bytes.delete();
    for (int k = 0; k < cnt; k++) bytes.push_back(seq ? 8'(k) : 8'($urandom_range(255)));
    reject = (cnt == 0) || (int'(base) + cnt > 256);
    we_q.delete(); done_q.delete(); acc_q.delete();
    proto_errs = 0;

    @(posedge clk); #1;
    start = 1'b1; base_addr = base; byte_count = 16'(cnt);
    @(posedge clk); #1;
    start = 1'b0; base_addr = $urandom_range(255); byte_count = 16'($urandom_range(50));

    if (reject) begin
      check("reject done", 64'(done), 64'd1);
      check("reject busy/ready", 64'({busy, s_ready}), 64'd0);
      check("reject err", 64'(err_overflow), 64'(cnt != 0));
      check("reject pointer", 64'(write_pointer_out), 64'(base));
      repeat (3) @(negedge clk);
      check("reject no write", 64'(we_q.size()), 64'd0);
      check("reject one done", 64'(done_q.size()), 64'd1);
      check("reject err sticky", 64'(err_overflow), 64'(cnt != 0));
      check("reject protocol", 64'(proto_errs), 64'd0);
      return;
    end

    check("start ready", 64'({s_ready, busy}), 64'b11);
    check("start err clr", 64'(err_overflow), 64'd0);

    i = 0; budget = 0; poked = 1'b0;
    while (i < cnt && budget < cnt * 40 + 50) begin
      s_valid = ($urandom_range(99) < pct);
      s_data  = bytes[i];
      if (poke && !poked && i == cnt / 2) begin
        start = 1'b1; base_addr = 8'd0; byte_count = 16'd3; poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (s_valid && s_ready) begin
        acc_q.push_back(cyc);
        i++;
      end
      budget++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0; start = 1'b0;
    check("all bytes accepted", 64'(i), 64'(cnt));

    budget = 0;
    while (done_q.size() == 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    repeat (2) @(negedge clk);

    // Model: window k covers bytes 4k .. 4k+3, truncated by the session length.
    nwin = (cnt + 3) / 4;
    check("write count", 64'(we_q.size()), 64'(nwin));
    for (int k = 0; k < nwin && k < we_q.size(); k++) begin
      lanes_n  = (cnt - 4 * k < 4) ? cnt - 4 * k : 4;
      exp_data = 0;
      for (int j = 0; j < lanes_n; j++) exp_data += 32'(bytes[4 * k + j]) << (8 * j);
      check("wr_addr", 64'(we_q[k].addr), 64'((int'(base) + 4 * k) % 256));
      check("wr_data", 64'(we_q[k].data), 64'(exp_data));
      check("wr_shift", 64'(we_q[k].shift), 64'(lanes_n - 1));
      idx = 4 * k + lanes_n - 1;
      if (idx < acc_q.size())
        check("we latency", 64'(we_q[k].cyc), 64'(acc_q[idx] + 1));
    end
    check("one done", 64'(done_q.size()), 64'd1);
    if (done_q.size() > 0 && we_q.size() > 0) begin
      w = we_q.size() - 1;
      check("done timing", 64'(done_q[0]), 64'(we_q[w].cyc + 1));
    end
    check("final pointer", 64'(write_pointer_out), 64'((int'(base) + cnt) % 256));
    check("end idle", 64'({busy, s_ready, err_overflow}), 64'd0);
    check("protocol", 64'(proto_errs), 64'd0);
  endtask

  initial begin
    int n;

    // Reset state.
    #3;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("after reset release");

    // Directed sessions from the test plan.
    run_session(8'd200, 8, 100, 1'b1, 1'b0);
    run_session(8'd10, 6, 100, 1'b1, 1'b0);
    run_session(8'd250, 7, 100, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("overflow sticky while idle", 64'(err_overflow), 64'd1);
    run_session(8'd252, 4, 50, 1'b0, 1'b1);
    run_session(8'd0, 0, 100, 1'b0, 1'b0);
    run_session(8'd252, 5, 100, 1'b0, 1'b0);

    // Reset mid-session after 3 of 4 bytes.
    we_q.delete();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'd100; byte_count = 16'd4;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    for (int t = 0; t < 20 && n < 3; t++) begin
      s_valid = 1'b1; s_data = 8'(8'hA0 + n);
      @(negedge clk);
      if (s_ready) n++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    check("pre-reset bytes", 64'(n), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("mid-session reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("no partial write", 64'(we_q.size()), 64'd0);
    run_session(8'd100, 4, 100, 1'b0, 1'b0);

    // Randomized sessions.
    for (int s = 0; s < 14; s++)
      run_session(8'($urandom_range(255)), int'($urandom_range(40)),
                  int'($urandom_range(100, 30)), 1'b0, ($urandom_range(1) == 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
